median_window_feeder: RTL and testbench
=======================================

Name: median_window_feeder

Overview:
- Turns a raster pixel stream into vertical 3-pixel columns for the median/black-level path.
- Each output word is already packed for the 3-input sorter: {row y-2, row y-1, row y} at the same column, MSB first.
- Uses two internal line buffers and row/column counters.
- Sits between the pixel input stage and the comparator/median stage. It is the producer side of the sorter's packed 3-pixel input.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- IMG_WIDTH, 640, pixels per line; must be >= 2.
- IMG_HEIGHT, 480, lines per frame; must be >= 3.
- ADDR_WIDTH, 10, column counter / line-buffer address width; must satisfy 2**ADDR_WIDTH >= IMG_WIDTH.
- ROW_WIDTH, 9, row counter width; must satisfy 2**ROW_WIDTH >= IMG_HEIGHT.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data carries a pixel this cycle.
- in_sof  input  1  start of frame; sampled only when in_valid=1.
- in_data  input  DATA_WIDTH  pixel, raster order.
- out_valid  output  1  out_data holds a complete column.
- out_data  output  3*DATA_WIDTH  [3W-1:2W]=row y-2, [2W-1:W]=row y-1, [W-1:0]=row y.
- out_eol  output  1  with out_valid: column is the last of its line (col = IMG_WIDTH-1).
- out_eof  output  1  with out_valid: column is the last of the frame (row = IMG_HEIGHT-1, col = IMG_WIDTH-1).

Behaviour:
- Reset:
  - Clock is single; reset is asynchronous, active-low.
  - While rst_n=0: col_cnt=0, row_cnt=0, out_valid=0, out_data=0, out_eol=0, out_eof=0.
  - Line-buffer contents are not cleared. Stale data is masked by the row gating below.
- No backpressure:
  - All state advances only on cycles with in_valid=1.
  - Idle cycles (in_valid=0) hold the counters. out_valid drops to 0 on the following edge; out_data holds its last value.
- Line buffers:
  - lb1[] holds line y-1; lb0[] holds line y-2; both have depth IMG_WIDTH.
  - On an accepted pixel p at column c, both buffers are read before they are written (read-old):
    - registered out_data <= {lb0[c], lb1[c], p}
    - lb0[c] <= lb1[c]
    - lb1[c] <= p
- Latency: exactly 1 cycle from accepted pixel to out_valid/out_data.
- Row gating (column position uses the effective counters, after any sof override):
  - out_valid <= in_valid AND (row_cnt >= 2).
  - out_eol <= in_valid AND (col_cnt = IMG_WIDTH-1).
  - out_eof <= out_eol condition AND (row_cnt = IMG_HEIGHT-1).
  - Rows 0 and 1 of every frame produce no output. Number of out_valid pulses per frame = IMG_WIDTH*(IMG_HEIGHT-2).
- Counters:
  - col_cnt increments per accepted pixel. At IMG_WIDTH-1 it wraps to 0 and row_cnt increments.
  - row_cnt wraps to 0 after the last pixel of row IMG_HEIGHT-1. The next frame again suppresses its first 2 rows.
- Start of frame:
  - in_valid=1 with in_sof=1: that pixel is treated as row 0, col 0, regardless of the counter state. The next pixel is col 1.
  - This resynchronises a truncated frame. The sof pixel itself produces no output.
  - in_sof with in_valid=0 is ignored.
- Reset mid-frame: counters restart at 0, so the next pixel is row 0, col 0. No output until the third row has started.
- Arithmetic: no pixel arithmetic; data is passed bit-exact. Full range 0..2**DATA_WIDTH-1 must survive unchanged.

Test Plan:
- Basic column packing, nominal (IMG_WIDTH=4, IMG_HEIGHT=4, DATA_WIDTH=8; pixel = row*16+col, continuous in_valid, in_sof on the first pixel):
  - no out_valid during rows 0-1.
  - one cycle after pixel (2,0): out_data=0x001020.
  - after (3,3): out_data=0x132333 with out_eol=1, out_eof=1.
  - exactly 8 out_valid pulses in total.
- Input gaps: same image with in_valid dropped on every other cycle -> identical out_data sequence to the nominal case; out_valid never asserted in the cycle after an idle cycle.
- Frame wrap: two back-to-back frames, no in_sof on the second -> second frame's rows 0-1 give no output; its first output (2,0) = 0x001020 (frame-2 data only); 16 out_valid pulses in total.
- SOF resync: assert in_sof on the pixel at row 1, col 2 of frame 1 -> counters restart. The outputs that follow reflect new-frame rows only, starting from the first pixel of the new row 2.
- Reset mid-frame: pull rst_n low asynchronously during row 2, col 1 -> out_valid=0 and out_data=0 immediately, with no clock edge needed. After release, restart the image -> nominal sequence reproduced.
- Full range (DATA_WIDTH=12): pixels 0xFFF, 0x000, 0xABC stacked in one column -> out_data=0xFFF000ABC.

Source files
------------

// File: rtl/median_window_feeder.sv
// median_window_feeder: packs raster pixels into vertical 3-pixel columns {y-2, y-1, y} for the median sorter
module median_window_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int ADDR_WIDTH = 10,
  parameter int ROW_WIDTH  = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_sof,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  output logic [3*DATA_WIDTH-1:0] out_data,
  output logic                    out_eol,
  output logic                    out_eof
);
  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(IMG_WIDTH - 1);
  localparam logic [ROW_WIDTH-1:0]  LAST_ROW = ROW_WIDTH'(IMG_HEIGHT - 1);
  logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
  logic [ADDR_WIDTH-1:0] col_cnt, col;
  logic [ROW_WIDTH-1:0]  row_cnt, row;
  logic                  last_col, last_row;
  // effective position: a start-of-frame pixel is forced to row 0, col 0
  always_comb begin
    col      = in_sof ? '0 : col_cnt;
    row      = in_sof ? '0 : row_cnt;
    last_col = col == LAST_COL;
    last_row = row == LAST_ROW;
  end
  // line buffers shift down one line per accepted pixel; contents are never cleared, rows 0-1 mask stale data
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb0[col] <= lb1[col];
      lb1[col] <= in_data;
    end
  end
  // counters and registered column output, advancing only on accepted pixels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt   <= '0;
      row_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      out_valid <= in_valid && (row >= ROW_WIDTH'(2));
      out_eol   <= in_valid && last_col;
      out_eof   <= in_valid && last_col && last_row;
      if (in_valid) begin
        out_data <= {lb0[col], lb1[col], in_data};
        col_cnt  <= last_col ? '0 : col + 1'b1;
        row_cnt  <= last_col ? (last_row ? '0 : row + 1'b1) : row;
      end
    end
  end
endmodule

// File: tb/tb_median_window_feeder.sv
// tb_median_window_feeder: scoreboard bench for the 3-row column packer
module tb_median_window_feeder;
  localparam int W = 4;
  localparam int H = 4;
  typedef struct packed {
    logic [23:0] d;
    logic        eol;
    logic        eof;
  } exp_t;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0, in_sof = 0;
  logic [7:0]  in_data = 0;
  logic        out_valid, out_eol, out_eof;
  logic [23:0] out_data;
  logic        v2 = 0, s2 = 0;
  logic [11:0] d2 = 0;
  logic        ov2, eol2, eof2;
  logic [35:0] od2;
  int          n_tests = 0, n_fail = 0, pulses = 0;
  exp_t        q[$];
  logic        exp_v = 0;
  logic [7:0]  img [H][W];
  int          mr = 0, mc = 0;

  median_window_feeder #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_WIDTH(2), .ROW_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_eol(out_eol), .out_eof(out_eof));

  median_window_feeder #(.DATA_WIDTH(12), .IMG_WIDTH(2), .IMG_HEIGHT(3), .ADDR_WIDTH(1), .ROW_WIDTH(2)) dut12 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_sof(s2), .in_data(d2),
    .out_valid(ov2), .out_data(od2), .out_eol(eol2), .out_eof(eof2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic px(input logic [7:0] d, input logic s, input logic v);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    @(posedge clk);
    #1;
    exp_v = 0;
    if (v) begin
      if (s) begin
        mr = 0;
        mc = 0;
      end
      exp_v = mr >= 2;
      if (exp_v) q.push_back({img[mr-2][mc], img[mr-1][mc], d, mc == W-1, mc == W-1 && mr == H-1});
      img[mr][mc] = d;
      if (mc == W-1) begin
        mc = 0;
        mr = (mr == H-1) ? 0 : mr + 1;
      end else mc++;
    end
  endtask

  task automatic frame(input int base, input bit sof, input bit gaps);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        px(8'(base + r*16 + c), sof && r == 0 && c == 0, 1'b1);
        if (gaps) px(8'($urandom), 1'b1, 1'b0);
      end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) px(8'h00, 1'b0, 1'b0);
  endtask

  task automatic px12(input logic [11:0] d, input logic s);
    v2 = 1;
    s2 = s;
    d2 = d;
    @(posedge clk);
    #1;
    v2 = 0;
  endtask

  always @(negedge clk) begin
    chk("out_valid", {63'd0, out_valid}, {63'd0, exp_v});
    if (out_valid) begin
      pulses++;
      if (q.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("out_data", {40'd0, out_data}, {40'd0, e.d});
        chk("out_eol", {63'd0, out_eol}, {63'd0, e.eol});
        chk("out_eof", {63'd0, out_eof}, {63'd0, e.eof});
      end
    end
  end

  initial begin
    #3;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_data", {40'd0, out_data}, 64'd0);
    chk("rst_eol_eof", {62'd0, out_eol, out_eof}, 64'd0);
    @(posedge clk);
    #3 rst_n = 1;
    // nominal frame
    pulses = 0;
    for (int c = 0; c < W; c++) px(8'(c), c == 0, 1'b1);
    for (int c = 0; c < W; c++) px(8'(16 + c), 1'b0, 1'b1);
    chk("rows01_silent", 64'(pulses), 64'd0);
    px(8'h20, 1'b0, 1'b1);
    chk("first_col", {40'd0, out_data}, 64'h001020);
    for (int c = 1; c < W; c++) px(8'(32 + c), 1'b0, 1'b1);
    for (int c = 0; c < W; c++) px(8'(48 + c), 1'b0, 1'b1);
    chk("last_col", {40'd0, out_data}, 64'h132333);
    chk("last_eol_eof", {62'd0, out_eol, out_eof}, 64'd3);
    idle(2);
    chk("nominal_pulses", 64'(pulses), 64'd8);
    // input gaps with sof asserted on idle cycles
    pulses = 0;
    frame(0, 1'b1, 1'b1);
    idle(2);
    chk("gap_pulses", 64'(pulses), 64'd8);
    // frame wrap: second frame without sof, distinct data
    pulses = 0;
    frame(0, 1'b1, 1'b0);
    frame(8'h80, 1'b0, 1'b0);
    idle(2);
    chk("wrap_pulses", 64'(pulses), 64'd16);
    // sof resync mid row 1
    pulses = 0;
    for (int c = 0; c < W; c++) px(8'(c), c == 0, 1'b1);
    px(8'h10, 1'b0, 1'b1);
    px(8'h11, 1'b0, 1'b1);
    frame(8'h40, 1'b1, 1'b0);
    idle(2);
    chk("resync_pulses", 64'(pulses), 64'd8);
    // async reset during row 2, col 1
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < W; c++) px(8'(r*16 + c), r == 0 && c == 0, 1'b1);
    px(8'h20, 1'b0, 1'b1);
    #1;
    q.delete();
    exp_v = 0;
    mr = 0;
    mc = 0;
    rst_n = 0;
    #1;
    chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst_data", {40'd0, out_data}, 64'd0);
    @(posedge clk);
    #3 rst_n = 1;
    pulses = 0;
    frame(0, 1'b0, 1'b0);
    idle(2);
    chk("post_rst_pulses", 64'(pulses), 64'd8);
    chk("queue_drained", 64'(q.size()), 64'd0);
    // full range, 12-bit instance
    px12(12'hFFF, 1'b1);
    px12(12'h111, 1'b0);
    px12(12'h000, 1'b0);
    px12(12'h222, 1'b0);
    chk("w12_rows01", {63'd0, ov2}, 64'd0);
    px12(12'hABC, 1'b0);
    chk("w12_valid", {63'd0, ov2}, 64'd1);
    chk("w12_data", {28'd0, od2}, 64'hFFF000ABC);
    chk("w12_eol0", {62'd0, eol2, eof2}, 64'd0);
    px12(12'h333, 1'b0);
    chk("w12_data_last", {28'd0, od2}, 64'h111222333);
    chk("w12_eol_eof", {62'd0, eol2, eof2}, 64'd3);
    @(posedge clk);
    #1;
    chk("w12_idle_drop", {63'd0, ov2}, 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
